// File: rtl/cond_flag_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : cond_flag_unit_if
// Brief   : ALU flag write port plus condition query/response handshake.
// Revision: 1.0 - initial release
// ============================================================================
interface cond_flag_unit_if #(
    parameter int unsigned CNT_W = 8
);
    logic             flag_we;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             cond_valid;
    logic [3:0]       cond;
    logic             cond_ready;
    logic             take_valid;
    logic             take;
    logic             take_ready;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] take_count;

    // Producer/consumer side: ALU flags in, branch logic queries and consumes.
    modport master (
        output flag_we, negative, zero, carry, overflow,
        output cond_valid, cond, take_ready,
        input  cond_ready, take_valid, take, flags_q, take_count
    );

    modport slave (
        input  flag_we, negative, zero, carry, overflow,
        input  cond_valid, cond, take_ready,
        output cond_ready, take_valid, take, flags_q, take_count
    );
endinterface
`default_nettype wire

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : cond_flag_unit
// Brief   : NZCV flag register, condition-code evaluator with a one-deep
//           response register, and saturating taken-condition counter.
//           Optional macro COND_FLAG_BYPASS_EN forwards same-cycle flag
//           writes into query evaluation.
// Revision: 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int unsigned CNT_W     = 8,
    parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
    input wire logic           clk,
    input wire logic           rst,
    cond_flag_unit_if.slave    bus
);
    localparam logic [0:0]       S_EMPTY   = 1'b0;
    localparam logic [0:0]       S_FULL    = 1'b1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_take;
    logic             w_take_nxt;
    logic [3:0]       r_flags;
    logic [3:0]       w_eval_flags;
    logic [CNT_W-1:0] r_count;
    logic             w_take_valid;
    logic             w_cond_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_cond_true;
    logic             w_n, w_z, w_c, w_v;

    assign w_take_valid = (r_state == S_FULL);
    assign w_cond_ready = !w_take_valid || bus.take_ready;
    assign w_accept     = bus.cond_valid && w_cond_ready;
    assign w_consume    = w_take_valid && bus.take_ready;

`ifdef COND_FLAG_BYPASS_EN
    assign w_eval_flags = bus.flag_we ? {bus.negative, bus.zero, bus.carry, bus.overflow}
                                      : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    assign {w_n, w_z, w_c, w_v} = w_eval_flags;

    always_comb begin
        w_cond_true = 1'b0;
        unique case (bus.cond)
            4'h0: w_cond_true = w_z;
            4'h1: w_cond_true = !w_z;
            4'h2: w_cond_true = w_c;
            4'h3: w_cond_true = !w_c;
            4'h4: w_cond_true = w_n;
            4'h5: w_cond_true = !w_n;
            4'h6: w_cond_true = w_v;
            4'h7: w_cond_true = !w_v;
            4'h8: w_cond_true = w_c && !w_z;
            4'h9: w_cond_true = !w_c || w_z;
            4'hA: w_cond_true = (w_n == w_v);
            4'hB: w_cond_true = (w_n != w_v);
            4'hC: w_cond_true = !w_z && (w_n == w_v);
            4'hD: w_cond_true = w_z || (w_n != w_v);
            4'hE: w_cond_true = 1'b1;
            4'hF: w_cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_take  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_take  <= w_take_nxt;
        end
    end

    // In FULL an accept implies take_ready, so the held response is consumed.
    always_comb begin
        w_state_nxt = r_state;
        w_take_nxt  = r_take;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_take_nxt  = w_cond_true;
                end
            end
            S_FULL: begin
                if (w_accept) begin
                    w_take_nxt = w_cond_true;
                end else if (w_consume) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= RST_FLAGS;
        end else if (bus.flag_we) begin
            r_flags <= {bus.negative, bus.zero, bus.carry, bus.overflow};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_consume && r_take && (r_count != C_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.cond_ready = w_cond_ready;
    assign bus.take_valid = w_take_valid;
    assign bus.take       = r_take;
    assign bus.flags_q    = r_flags;
    assign bus.take_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cond_flag_unit
// Brief   : Self-checking bench; two instances (8-bit and 2-bit counters)
//           share stimulus and are compared against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;
    localparam logic [3:0] C_RST_FLAGS = 4'b0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_we, negative, zero, carry, overflow;
    logic       cond_valid, take_ready;
    logic [3:0] cond;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_flags;
    bit         m_valid;
    bit         m_take;
    int         m_cnt;

    always #5 clk = ~clk;

    cond_flag_unit_if #(.CNT_W(8)) bus8 ();
    cond_flag_unit_if #(.CNT_W(2)) bus2 ();

    assign bus8.flag_we = flag_we;     assign bus2.flag_we = flag_we;
    assign bus8.negative = negative;   assign bus2.negative = negative;
    assign bus8.zero = zero;           assign bus2.zero = zero;
    assign bus8.carry = carry;         assign bus2.carry = carry;
    assign bus8.overflow = overflow;   assign bus2.overflow = overflow;
    assign bus8.cond_valid = cond_valid; assign bus2.cond_valid = cond_valid;
    assign bus8.cond = cond;           assign bus2.cond = cond;
    assign bus8.take_ready = take_ready; assign bus2.take_ready = take_ready;

    cond_flag_unit #(.CNT_W(8), .RST_FLAGS(C_RST_FLAGS)) u_dut8 (
        .clk (clk), .rst (rst), .bus (bus8.slave)
    );
    cond_flag_unit #(.CNT_W(2), .RST_FLAGS(C_RST_FLAGS)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    // Table grouped in pairs: odd codes are the negation of the even code below.
    function automatic bit eval_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("take_valid8", {31'd0, bus8.take_valid}, {31'd0, m_valid});
        chk("take_valid2", {31'd0, bus2.take_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("take8", {31'd0, bus8.take}, {31'd0, m_take});
            chk("take2", {31'd0, bus2.take}, {31'd0, m_take});
        end
        chk("flags_q8", {28'd0, bus8.flags_q}, {28'd0, m_flags});
        chk("flags_q2", {28'd0, bus2.flags_q}, {28'd0, m_flags});
        chk("take_count8", {24'd0, bus8.take_count}, sat(m_cnt, 255));
        chk("take_count2", {30'd0, bus2.take_count}, sat(m_cnt, 3));
    endtask

    task automatic model_reset();
        m_flags = C_RST_FLAGS;
        m_valid = 1'b0;
        m_take  = 1'b0;
        m_cnt   = 0;
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic cycle();
        bit acc, con;
        logic [3:0] ef;
        #1;
        chk("cond_ready8", {31'd0, bus8.cond_ready}, {31'd0, (!m_valid || take_ready)});
        chk("cond_ready2", {31'd0, bus2.cond_ready}, {31'd0, (!m_valid || take_ready)});
        con = m_valid && take_ready;
        acc = cond_valid && (!m_valid || take_ready);
        ef  = m_flags;
`ifdef COND_FLAG_BYPASS_EN
        if (flag_we) ef = {negative, zero, carry, overflow};
`endif
        @(posedge clk);
        if (con && m_take) m_cnt++;
        if (acc) begin
            m_take  = eval_cond(cond, ef);
            m_valid = 1'b1;
        end else if (con) begin
            m_valid = 1'b0;
        end
        if (flag_we) m_flags = {negative, zero, carry, overflow};
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit we, input logic [3:0] f, input bit cv,
                         input logic [3:0] c, input bit tr);
        flag_we = we;
        {negative, zero, carry, overflow} = f;
        cond_valid = cv;
        cond = c;
        take_ready = tr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_take_valid", {31'd0, bus8.take_valid}, 32'd0);
        chk("rst_take", {31'd0, bus8.take}, 32'd0);
        chk("rst_count8", {24'd0, bus8.take_count}, 32'd0);
        chk("rst_count2", {30'd0, bus2.take_count}, 32'd0);
        chk("rst_flags", {28'd0, bus8.flags_q}, {28'd0, C_RST_FLAGS});
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_cond_ready", {31'd0, bus8.cond_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs();
        chk("init_cond_ready", {31'd0, bus8.cond_ready}, 32'd1);

        // Full table sweep
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, f[3:0], 1'b0, 4'h0, 1'b1);
            cycle();
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 4'h0, 1'b1, c[3:0], 1'b1);
                cycle();
            end
        end
        drive(1'b1, 4'b1001, 1'b0, 4'h0, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 4'hB, 1'b1);
        cycle();
        chk("lt_1001", {31'd0, bus8.take}, 32'd0);
        drive(1'b1, 4'b1000, 1'b0, 4'h0, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 4'hB, 1'b1);
        cycle();
        chk("lt_1000", {31'd0, bus8.take}, 32'd1);

        // Asynchronous reset while a response is held
        drive(1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        #2;
        do_reset();

        // Back-pressure
        drive(1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 1'b1, 4'hF, 1'b0);
            cycle();
            chk("bp_take_held", {31'd0, bus8.take}, 32'd1);
            chk("bp_cond_ready", {31'd0, bus8.cond_ready}, 32'd0);
        end
        drive(1'b0, 4'h0, 1'b1, 4'hF, 1'b1);
        cycle();
        chk("bp_replaced", {31'd0, bus8.take}, 32'd0);
        chk("bp_count", {24'd0, bus8.take_count}, 32'd1);

        // Same-cycle flag write and EQ query
        drive(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1);
        cycle();
        drive(1'b1, 4'b0100, 1'b1, 4'h0, 1'b1);
        cycle();
`ifdef COND_FLAG_BYPASS_EN
        chk("bypass_eq", {31'd0, bus8.take}, 32'd1);
`else
        chk("bypass_eq", {31'd0, bus8.take}, 32'd0);
`endif

        // Counter saturation
        #2;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 4'h0, 1'b1, (i < 5) ? 4'hE : 4'hF, 1'b1);
            cycle();
        end
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        cycle();
        chk("sat_count2", {30'd0, bus2.take_count}, 32'd3);
        chk("sat_count8", {24'd0, bus8.take_count}, 32'd5);

        // Streaming EQ/NE with Z=1
        #2;
        do_reset();
        drive(1'b1, 4'b0100, 1'b0, 4'h0, 1'b1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0, 1'b1, {3'b000, i[0]}, 1'b1);
            cycle();
            chk("stream_valid", {31'd0, bus8.take_valid}, 32'd1);
            chk("stream_take", {31'd0, bus8.take}, {31'd0, ~i[0]});
        end
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        cycle();
        chk("stream_count", {24'd0, bus8.take_count}, 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) == 0, 4'($urandom), 1'($urandom),
                  4'($urandom), ($urandom % 4) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cond_flag_unit.md
# cond_flag_unit

- Registers the NZCV flags produced by the team's 4-bit ALU slices, such as the AND/flags slice.
- Evaluates 4-bit condition codes against those flags over a valid/ready query/response handshake.
- Keeps a saturating count of taken conditions.
- Sits between the ALU flag outputs and the branch/predication logic; it is the consumer end of the ALU flags interface.

## Interface
Parameters:
- CNT_W, 8, width of the taken-condition counter
- RST_FLAGS, 4'b0000, reset value of {N,Z,C,V}

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flag_we  in  1  capture flags this cycle
- negative  in  1  ALU N flag
- zero  in  1  ALU Z flag
- carry  in  1  ALU C flag
- overflow  in  1  ALU V flag
- cond_valid  in  1  condition query present
- cond  in  4  condition code
- cond_ready  out  1  query accepted when cond_valid & cond_ready
- take_valid  out  1  response present
- take  out  1  1 = condition true
- take_ready  in  1  response consumed when take_valid & take_ready
- flags_q  out  4  registered {N,Z,C,V}
- take_count  out  CNT_W  saturating count of accepted responses with take=1

## Operation
- Flag register: on flag_we, flags_q <= {negative, zero, carry, overflow}.
  - flag_we is always honoured; there is no back-pressure on flags.
- Condition codes (F = flags used for evaluation):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Response stage: single output register with states EMPTY (take_valid=0) and FULL (take_valid=1).
  - cond_ready = !take_valid | take_ready, a combinational pass-through of downstream readiness.
  - EMPTY -> FULL on query accept.
  - FULL -> EMPTY on response consume with no new accept.
  - FULL -> FULL on consume plus accept in the same cycle: take is replaced and take_valid stays 1.
  - FULL and !take_ready: take and take_valid hold stable and cond_ready=0.
- Counter: take_count increments by 1 when a response is consumed and take=1.
  - It saturates at 2^CNT_W-1 and never wraps.
- Reset (asynchronous, any time, including mid-handshake):
  - flags_q = RST_FLAGS, take_valid = 0, take = 0, take_count = 0.
  - cond_ready therefore reads 1.
  - A pending response is discarded.

## Timing
- Query-to-response latency is 1 cycle: a query accepted at edge k gives take_valid=1 after edge k.
- Full throughput of 1 query/cycle while take_ready=1.
- flags_q updates 1 cycle after flag_we.
- Simultaneous flag_we and query accept: see Configuration.
- take_count updates on the edge that consumes the response; it is visible the following cycle.
- No combinational path from cond_valid to any output.
- cond_ready depends combinationally on take_ready only.

## Configuration
- COND_FLAG_BYPASS_EN defined:
  - A query accepted in the same cycle as flag_we evaluates against the incoming flag inputs.
  - This is a write-to-evaluate forward.
- COND_FLAG_BYPASS_EN undefined:
  - Queries always evaluate against flags_q, the pre-write value.
  - Same-cycle writes become visible to queries one cycle later.

## Test plan
- Reset check: assert rst mid-response with take_valid=1.
  - Required: take_valid=0, take_count=0, flags_q=RST_FLAGS immediately; cond_ready=1 after release.
- Full table sweep: for all 16 flag values, write flags then query all 16 cond codes with take_ready=1.
  - Required: take matches the table.
  - Example: flags 4'b1001 with cond B (LT) -> take=0; flags 4'b1000 with cond B -> take=1.
- Back-pressure: take_ready=0 for 3 cycles after a response with cond=E (take=1).
  - Required: take_valid and take held, cond_ready=0 throughout.
  - Then take_ready=1: consumed, and a queued query is accepted in the same cycle.
- Bypass: flags_q=4'b0000; same cycle flag_we with zero=1 and query cond=0 (EQ).
  - Required: take=1 with COND_FLAG_BYPASS_EN defined, take=0 without it.
- Counter saturation with CNT_W=2: consume 5 AL responses and 2 NV responses.
  - Required: take_count reaches 3 and stays at 3.
- Streaming: 8 back-to-back queries alternating EQ/NE with Z=1 and take_ready=1.
  - Required: take sequence 1,0,1,0,... one response per cycle, no gaps, take_count=4.
